// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: packet-locked round-robin grant of one downstream channel among WIDTH requesters
module rr_pri2oht #(
  parameter int W = 4,
  parameter int IMPLEMENTATION = 0
) (
  input  logic [W-1:0] c,
  output logic [W-1:0] o
);
  generate
    if (IMPLEMENTATION == 0) begin : g_add
      assign o = c & (~c + W'(1));
    end else if (IMPLEMENTATION == 1) begin : g_loop
      always_comb begin
        o = '0;
        for (int i = W - 1; i >= 0; i--) o = c[i] ? W'(1) << i : o;
      end
    end else begin : g_vec
      assign o = c & ~(c - W'(1));
    end
  endgenerate
endmodule

module round_robin_arbiter #(
  parameter int WIDTH = 4,
  parameter int IMPLEMENTATION = 0,
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     req_vld,
  input  logic [WIDTH-1:0]     req_lst,
  output logic [WIDTH-1:0]     req_rdy,
  output logic                 grt_vld,
  output logic                 grt_lst,
  input  logic                 grt_rdy,
  output logic [WIDTH-1:0]     grt_oht,
  output logic [WIDTH_LOG-1:0] grt_idx,
  output logic                 grt_bsy
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] ptr, ptr_nxt, grt_oht_nxt, msk, cand, oh_m, oh_a, sel;
  logic rel, arb;
  rr_pri2oht #(.W(WIDTH), .IMPLEMENTATION(IMPLEMENTATION)) u_m (.c(cand & msk), .o(oh_m));
  rr_pri2oht #(.W(WIDTH), .IMPLEMENTATION(IMPLEMENTATION)) u_a (.c(cand), .o(oh_a));
  always_comb begin
    msk = ~(ptr | (ptr - WIDTH'(1)));
    cand = state == BUSY ? req_vld & ~grt_oht : req_vld;
    sel = |(cand & msk) ? oh_m : oh_a;
    grt_bsy = state == BUSY;
    grt_vld = grt_bsy && |(req_vld & grt_oht);
    grt_lst = grt_bsy && |(req_lst & req_vld & grt_oht);
    req_rdy = grt_bsy ? grt_oht & {WIDTH{grt_rdy}} : '0;
    rel = grt_vld && grt_rdy && grt_lst;
    arb = grt_bsy ? rel : |req_vld;
    // sel is zero when nobody else waits, which both clears the grant and keeps ptr
    grt_oht_nxt = arb ? sel : grt_oht;
    ptr_nxt = arb && |sel ? sel : ptr;
    state_nxt = arb ? (|sel ? BUSY : IDLE) : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grt_oht <= '0;
      ptr <= WIDTH'(1) << (WIDTH - 1);
    end else begin
      state <= state_nxt;
      grt_oht <= grt_oht_nxt;
      ptr <= ptr_nxt;
    end
  end
  always_comb begin
    grt_idx = '0;
    for (int i = 0; i < WIDTH; i++) grt_idx = grt_oht[i] ? grt_idx | WIDTH_LOG'(i) : grt_idx;
  end
endmodule

// File: doc/round_robin_arbiter.md
# round_robin_arbiter

Packet-level round-robin arbiter sharing one downstream channel among `WIDTH` requesters. Each arbitration round uses priority-to-onehot selection (rightmost set bit) twice: once on requests masked above the last winner, once on all requests as fallback. The grant is registered and locked for a whole multi-beat packet, and is released on the last beat. The arbiter carries only control; the parent muxes payload with `grt_oht`.

## Interface
- `WIDTH`, 4: number of requesters; must be ≥ 2.
- `WIDTH_LOG`, `$clog2(WIDTH)`: localparam, index width.
- `IMPLEMENTATION`, 0: passed to both priority-to-onehot instances (0 adder, 1 loop, 2 vector). It affects only structure, never behaviour.

Ports:
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `req_vld`  input  WIDTH  per-requester beat valid.
- `req_lst`  input  WIDTH  per-requester last beat of packet; qualified by `req_vld`.
- `req_rdy`  output  WIDTH  per-requester beat accepted.
- `grt_vld`  output  1  downstream beat valid.
- `grt_lst`  output  1  downstream last beat.
- `grt_rdy`  input  1  downstream ready.
- `grt_oht`  output  WIDTH  registered one-hot owner; all-zero when idle.
- `grt_idx`  output  WIDTH_LOG  binary index of owner; 0 when idle.
- `grt_bsy`  output  1  channel owned (state BUSY).

## Operation
- **States:** IDLE and BUSY. Registers are `state`, `grt_oht` and `ptr`.
  - `ptr` is the one-hot of the last winner.
  - `grt_idx` is encoded from `grt_oht`, either registered alongside it or combinational.
- **Mask:** `msk[i] = 1` for every `i` strictly above the set bit of `ptr`.
- **Selection for candidate vector `c`:**
  - `sel = onehot(c & msk)` if `|(c & msk)`.
  - Otherwise `sel = onehot(c)`.
  - `onehot` is the rightmost set bit, LSB has priority.
- **IDLE:**
  - If `|req_vld`: load `grt_oht <= sel(req_vld)`, `ptr <= sel(req_vld)`, go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY, combinational outputs:**
  - `grt_vld = |(req_vld & grt_oht)`.
  - `grt_lst = |(req_lst & req_vld & grt_oht)`.
  - `req_rdy = grt_oht & {WIDTH{grt_rdy}}`.
- **Transfer:** `xfr = grt_vld & grt_rdy`.
- **Release:** `xfr & grt_lst`.
  - Candidates are `n = req_vld & ~grt_oht`, so the current owner is excluded from back-to-back.
  - If `|n`: `grt_oht <= sel(n)`, `ptr <= sel(n)`, stay in BUSY (no bubble).
  - Otherwise `grt_oht <= 0` and go to IDLE; `ptr` is unchanged.
- **No release** (non-last beat, or `grt_rdy` low, or owner `req_vld` low): all state holds. The grant is never revoked mid-packet.
- **IDLE outputs:** `grt_vld = 0`, `grt_lst = 0`, `req_rdy = 0`.
- **Requester rules:**
  - Once `req_vld[i]` is asserted it holds until accepted.
  - A dropped `req_vld` from the owner stalls the channel but keeps ownership.
  - Non-owners are ignored until arbitration.
- **Reset value of every output:** `req_rdy = 0`, `grt_vld = 0`, `grt_lst = 0`, `grt_oht = 0`, `grt_idx = 0`, `grt_bsy = 0`.
- **Reset value of internal state:** `ptr` = bit `WIDTH-1` (empty mask), so the first grant favours requester 0.
- **Reset mid-packet:** asynchronously return to IDLE with all the values above. In-flight packets are abandoned; no beat is reported after reset asserts.

## Timing
- **Grant latency from IDLE:** 1 cycle.
  - `req_vld` first high in cycle N gives `grt_oht` and `grt_bsy` in cycle N+1.
  - The first beat can transfer in N+1.
- `req_rdy` and `grt_vld` are combinational from registered `grt_oht` plus the inputs. The paths `grt_rdy`→`req_rdy` and `req_vld`→`grt_vld` are zero-latency.
- **Back-to-back:** the last beat in cycle M and a new owner in cycle M+1 with no idle cycle.
- **Re-grant to the same requester** with no other requests: last beat in M, IDLE in M+1, grant in M+2. This one-bubble rule is mandatory.
- **Throughput:** 1 beat per cycle while `grt_rdy = 1`.
- **Simultaneous events:** a request arriving in the release cycle participates in that arbitration if it is not the current owner.
- The reset deassertion edge needs no synchronizer inside the block; the parent guarantees a synchronous release.

## Test plan
- **Reset:** hold `rst_n` low with random `req_vld` → all outputs 0. After release with `req_vld = 4'b1010` (WIDTH=4) → `grt_oht = 4'b0010`, `grt_idx = 1` one cycle later.
- **Single packet:** requester 2 sends 3 beats (`req_lst` on beat 3), `grt_rdy = 1` → `req_rdy = 4'b0100` for exactly 3 cycles, then `grt_bsy = 0` the next cycle.
- **Round-robin fairness:** all four requesters hold single-beat packets continuously, `grt_rdy = 1` → grant order 0,1,2,3,0,1 with one transfer per cycle and no bubbles.
- **Backpressure:** hold `grt_rdy = 0` for 5 cycles mid-packet while others request → `grt_oht` and `ptr` unchanged, `req_rdy = 0`, and the packet resumes on `grt_rdy = 1`.
- **Self re-grant:** only requester 3 sends two consecutive single-beat packets → transfers in cycles M and M+2, `grt_bsy = 0` in M+1.
- **Reset mid-packet:** assert `rst_n = 0` during beat 2 of a 4-beat packet → outputs 0 immediately. After release a new request from requester 1 → `grt_oht = 4'b0010`.
